// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: arbitration state,
// default bus widths and the word geometry.
package dmem_pkg;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } arb_state_e;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 8;
  localparam int BYTES_PER_WORD = 4;
  // Wide enough for the largest legal STARVE_MAX of 15.
  localparam int STARVE_W       = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory port around the arbiter.
// slave = arbiter view; master = requesters plus data memory.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_stall;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              a_err;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              b_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_en_read;
  logic              mem_en_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_stall, a_rvalid, a_rdata, a_err,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata, b_err,
    output mem_addr, mem_wdata, mem_en_read, mem_en_write,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_stall, a_rvalid, a_rdata, a_err,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata, b_err,
    input  mem_addr, mem_wdata, mem_en_read, mem_en_write,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_rsp_reg.sv
// Per-port response register: captures read data at the end of a grant cycle
// and pulses rvalid (and err for rejected requests) for one cycle.
module dmem_rsp_reg
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_gnt,
  input  logic              i_we,
  input  logic              i_rej,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rvalid,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata
);

  logic              r_rvalid;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      // A rejected write still answers, so the requester always sees a response.
      r_rvalid <= i_gnt & (~i_we | i_rej);
      r_err    <= i_gnt & i_rej;
      if (i_gnt && i_rej) begin
        r_rdata <= '0;
      end else if (i_gnt && !i_we) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_err    = r_err;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: A (MEM stage) normally
// wins, B (loader/DMA) is protected by a starvation counter.
// Optional macro DMEM_ALIGN_CHECK_EN also rejects unaligned word accesses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input logic           clock,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);

  // Highest byte address at which a full word still fits.
  localparam logic [ADDR_W-1:0]   ADDR_LAST  = ADDR_W'((1 << ADDR_W) - BYTES_PER_WORD);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [STARVE_W-1:0] w_starve_nxt;
  logic                w_a_gnt;
  logic                w_b_gnt;
  logic                w_a_rej;
  logic                w_b_rej;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_a_rej = (bus.a_addr > ADDR_LAST) || (bus.a_addr[1:0] != 2'b00);
  assign w_b_rej = (bus.b_addr > ADDR_LAST) || (bus.b_addr[1:0] != 2'b00);
`else
  assign w_a_rej = (bus.a_addr > ADDR_LAST);
  assign w_b_rej = (bus.b_addr > ADDR_LAST);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= PRIO_A;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    w_starve_nxt = (bus.b_req && !w_b_gnt) ? r_starve_cnt + 1'b1 : '0;
    w_state_nxt  = r_state;
    case (r_state)
      PRIO_A:  if (w_starve_nxt == STARVE_LIM) w_state_nxt = PRIO_B;
      PRIO_B:  if (w_b_gnt || !bus.b_req)      w_state_nxt = PRIO_A;
      default: w_state_nxt = PRIO_A;
    endcase
  end

  // Grants are combinational so a lone requester is served in the same cycle.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    case (r_state)
      PRIO_A: begin
        w_a_gnt = bus.a_req;
        w_b_gnt = bus.b_req & ~bus.a_req;
      end
      PRIO_B: begin
        w_b_gnt = bus.b_req;
        w_a_gnt = bus.a_req & ~bus.b_req;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_en_read  = 1'b0;
    bus.mem_en_write = 1'b0;
    if (w_a_gnt) begin
      bus.mem_addr     = bus.a_addr;
      bus.mem_wdata    = bus.a_wdata;
      bus.mem_en_read  = ~bus.a_we;
      bus.mem_en_write = bus.a_we & ~w_a_rej;
    end else if (w_b_gnt) begin
      bus.mem_addr     = bus.b_addr;
      bus.mem_wdata    = bus.b_wdata;
      bus.mem_en_read  = ~bus.b_we;
      bus.mem_en_write = bus.b_we & ~w_b_rej;
    end
    // Memory stays quiet for the whole reset, including a write in flight.
    if (!reset_n) begin
      bus.mem_en_read  = 1'b0;
      bus.mem_en_write = 1'b0;
    end
  end

  assign bus.a_gnt   = w_a_gnt;
  assign bus.a_stall = bus.a_req & ~w_a_gnt;
  assign bus.b_gnt   = w_b_gnt;

  dmem_rsp_reg #(.DATA_W(DATA_W)) u_rsp_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_gnt       (w_a_gnt),
    .i_we        (bus.a_we),
    .i_rej       (w_a_rej),
    .i_mem_rdata (bus.mem_rdata),
    .o_rvalid    (bus.a_rvalid),
    .o_err       (bus.a_err),
    .o_rdata     (bus.a_rdata)
  );

  dmem_rsp_reg #(.DATA_W(DATA_W)) u_rsp_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_gnt       (w_b_gnt),
    .i_we        (bus.b_we),
    .i_rej       (w_b_rej),
    .i_mem_rdata (bus.mem_rdata),
    .o_rvalid    (bus.b_rvalid),
    .o_err       (bus.b_err),
    .o_rdata     (bus.b_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a one-cycle-per-row vector table plus
// hand-written reset sequences, against a byte-array memory model.
module tb_dmem_arbiter;

  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  dmem_arbiter #(.DATA_W(32), .ADDR_W(8), .STARVE_MAX(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Byte-addressed memory with combinational little-endian word read.
  logic [7:0] mem [256];
  logic       mem_loaded = 1'b0;
  logic [7:0] m1, m2, m3;

  assign m1 = bus.mem_addr + 8'd1;
  assign m2 = bus.mem_addr + 8'd2;
  assign m3 = bus.mem_addr + 8'd3;
  assign bus.mem_rdata = {mem[m3], mem[m2], mem[m1], mem[bus.mem_addr]};

  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[2]   <= 8'h11;
      mem[3]   <= 8'h22;
      mem[4]   <= 8'h0E;
      mem[252] <= 8'hA1;
      mem[253] <= 8'hA2;
      mem[254] <= 8'hA3;
      mem[255] <= 8'hA4;
      mem_loaded <= 1'b1;
    end else if (bus.mem_en_write) begin
      for (int k = 0; k < 4; k++) mem[bus.mem_addr + 8'(k)] <= bus.mem_wdata[8*k +: 8];
    end
  end

  function automatic logic [31:0] peek_word(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  typedef struct {
    logic        a_req, a_we;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_req, b_we;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic        e_a_gnt, e_a_stall, e_b_gnt, e_en_r, e_en_w;
    logic [7:0]  e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_a_rvalid, e_a_err;
    logic [31:0] e_a_rdata;
    logic        e_b_rvalid, e_b_err;
    logic [31:0] e_b_rdata;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic        UNAL_ERR   = 1'b1;
  localparam logic [31:0] UNAL_RDATA = 32'h0000_0000;
`else
  localparam logic        UNAL_ERR   = 1'b0;
  localparam logic [31:0] UNAL_RDATA = 32'h000E_2211;
`endif

  vec_t vecs[$];

  task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [31:0] ad,
                       input logic br, input logic bw, input logic [7:0] ba, input logic [31:0] bd);
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(L, L, 8'd0, 32'h0, L, L, 8'd0, 32'h0);

    //            A req/we/addr/wdata              B req/we/addr/wdata           a_gnt stall b_gnt en_r en_w addr wdata      A rv err rdata          B rv err rdata
    vecs.push_back('{L, L, 8'd0,   32'h0,        L, L, 8'd0,  32'h0,        L, L, L, L, L, 8'd0,   32'h0,        L, L, 32'h0,        L, L, 32'h0});
    vecs.push_back('{H, H, 8'd8,   32'hDEADBEEF, L, L, 8'd0,  32'h0,        H, L, L, L, H, 8'd8,   32'hDEADBEEF, L, L, 32'h0,        L, L, 32'h0});
    vecs.push_back('{H, L, 8'd8,   32'h0,        L, L, 8'd0,  32'h0,        H, L, L, H, L, 8'd8,   32'h0,        H, L, 32'hDEADBEEF, L, L, 32'h0});
    vecs.push_back('{L, L, 8'd0,   32'h0,        H, L, 8'd4,  32'h0,        L, L, H, H, L, 8'd4,   32'h0,        L, L, 32'hDEADBEEF, H, L, 32'h0000000E});
    vecs.push_back('{H, H, 8'd253, 32'h12345678, L, L, 8'd0,  32'h0,        H, L, L, L, L, 8'd253, 32'h12345678, H, H, 32'h0,        L, L, 32'h0000000E});
    vecs.push_back('{H, L, 8'd252, 32'h0,        L, L, 8'd0,  32'h0,        H, L, L, H, L, 8'd252, 32'h0,        H, L, 32'hA4A3A2A1, L, L, 32'h0000000E});
    vecs.push_back('{H, L, 8'd2,   32'h0,        L, L, 8'd0,  32'h0,        H, L, L, H, L, 8'd2,   32'h0,        H, UNAL_ERR, UNAL_RDATA, L, L, 32'h0000000E});
    vecs.push_back('{H, L, 8'd8,   32'h0,        H, H, 8'd12, 32'hCAFEF00D, H, L, L, H, L, 8'd8,   32'h0,        H, L, 32'hDEADBEEF, L, L, 32'h0000000E});
    vecs.push_back('{L, L, 8'd0,   32'h0,        H, H, 8'd12, 32'hCAFEF00D, L, L, H, L, H, 8'd12,  32'hCAFEF00D, L, L, 32'hDEADBEEF, L, L, 32'h0000000E});
    vecs.push_back('{L, L, 8'd0,   32'h0,        H, L, 8'd12, 32'h0,        L, L, H, H, L, 8'd12,  32'h0,        L, L, 32'hDEADBEEF, H, L, 32'hCAFEF00D});
    // Both ports held: four A grants, a forced B grant, then A again.
    for (int i = 0; i < 4; i++)
      vecs.push_back('{H, L, 8'd252, 32'h0,      H, L, 8'd4,  32'h0,        H, L, L, H, L, 8'd252, 32'h0,        H, L, 32'hA4A3A2A1, L, L, 32'hCAFEF00D});
    vecs.push_back('{H, L, 8'd252, 32'h0,        H, L, 8'd4,  32'h0,        L, H, H, H, L, 8'd4,   32'h0,        L, L, 32'hA4A3A2A1, H, L, 32'h0000000E});
    vecs.push_back('{H, L, 8'd252, 32'h0,        H, L, 8'd4,  32'h0,        H, L, L, H, L, 8'd252, 32'h0,        H, L, 32'hA4A3A2A1, L, L, 32'h0000000E});
    vecs.push_back('{L, L, 8'd0,   32'h0,        L, L, 8'd0,  32'h0,        L, L, L, L, L, 8'd0,   32'h0,        L, L, 32'hA4A3A2A1, L, L, 32'h0000000E});
    vecs.push_back('{H, H, 8'd252, 32'h11223344, L, L, 8'd0,  32'h0,        H, L, L, L, H, 8'd252, 32'h11223344, L, L, 32'hA4A3A2A1, L, L, 32'h0000000E});
    vecs.push_back('{H, L, 8'd252, 32'h0,        L, L, 8'd0,  32'h0,        H, L, L, H, L, 8'd252, 32'h0,        H, L, 32'h11223344, L, L, 32'h0000000E});
    vecs.push_back('{L, L, 8'd0,   32'h0,        H, L, 8'd253, 32'h0,       L, L, H, H, L, 8'd253, 32'h0,        L, L, 32'h11223344, H, H, 32'h0});

    // Reset state, and enables held low while reset is asserted.
    repeat (2) @(posedge clock);
    #1;
    drive(H, H, 8'd40, 32'h55, L, L, 8'd0, 32'h0);
    #1 checkb("rst en_write", bus.mem_en_write, L);
    bus.a_we = L;
    #1 checkb("rst en_read", bus.mem_en_read, L);
    drive(L, L, 8'd0, 32'h0, L, L, 8'd0, 32'h0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkb("rst a_rvalid", bus.a_rvalid, L);
    checkb("rst a_err", bus.a_err, L);
    check("rst a_rdata", bus.a_rdata, 32'h0);
    checkb("rst b_rvalid", bus.b_rvalid, L);
    checkb("rst b_err", bus.b_err, L);
    check("rst b_rdata", bus.b_rdata, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata,
            vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
      #4;
      checkb($sformatf("v%0d a_gnt", i), bus.a_gnt, vecs[i].e_a_gnt);
      checkb($sformatf("v%0d a_stall", i), bus.a_stall, vecs[i].e_a_stall);
      checkb($sformatf("v%0d b_gnt", i), bus.b_gnt, vecs[i].e_b_gnt);
      checkb($sformatf("v%0d en_read", i), bus.mem_en_read, vecs[i].e_en_r);
      checkb($sformatf("v%0d en_write", i), bus.mem_en_write, vecs[i].e_en_w);
      check($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_mem_addr));
      check($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].e_mem_wdata);
      @(posedge clock);
      #1;
      checkb($sformatf("v%0d a_rvalid", i), bus.a_rvalid, vecs[i].e_a_rvalid);
      checkb($sformatf("v%0d a_err", i), bus.a_err, vecs[i].e_a_err);
      check($sformatf("v%0d a_rdata", i), bus.a_rdata, vecs[i].e_a_rdata);
      checkb($sformatf("v%0d b_rvalid", i), bus.b_rvalid, vecs[i].e_b_rvalid);
      checkb($sformatf("v%0d b_err", i), bus.b_err, vecs[i].e_b_err);
      check($sformatf("v%0d b_rdata", i), bus.b_rdata, vecs[i].e_b_rdata);
    end
    check("rejected write left memory", peek_word(8'd252), 32'h11223344);

    // Reset right after a B read grant drops the pending response.
    drive(L, L, 8'd0, 32'h0, H, L, 8'd4, 32'h0);
    #4 checkb("mid b_gnt", bus.b_gnt, H);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    checkb("mid b_rvalid", bus.b_rvalid, L);
    check("mid b_rdata", bus.b_rdata, 32'h0);
    drive(H, H, 8'd20, 32'h5555AAAA, L, L, 8'd0, 32'h0);
    #2 checkb("mid en_write", bus.mem_en_write, L);
    @(posedge clock);
    #1 check("mid no write", peek_word(8'd20), 32'h0);
    drive(L, L, 8'd0, 32'h0, L, L, 8'd0, 32'h0);
    reset_n = 1'b1;
    @(posedge clock);
    #1 checkb("mid b_rvalid after", bus.b_rvalid, L);

    // Drive the FSM into PRIO_B with a full counter, reset, and expect a fresh start.
    drive(H, L, 8'd8, 32'h0, H, L, 8'd4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #4 checkb($sformatf("pre%0d a_gnt", i), bus.a_gnt, H);
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4;
      checkb($sformatf("post%0d a_gnt", i), bus.a_gnt, (i < 4) ? H : L);
      checkb($sformatf("post%0d b_gnt", i), bus.b_gnt, (i == 4) ? H : L);
      @(posedge clock);
      #1;
    end
    drive(L, L, 8'd0, 32'h0, L, L, 8'd0, 32'h0);
    @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
